seq_div_8x4: RTL and testbench
==============================

SEQ_DIV_8X4 -- requirements
Module: seq_div_8x4

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand pair valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 dividend  input  8  unsigned dividend, e.g. a product from the 4x4 multiplier.
REQ-007 divisor  input  4  unsigned divisor.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 quotient  output  8  unsigned quotient.
REQ-011 remainder  output  4  unsigned remainder.
REQ-012 div_by_zero  output  1  flag: the current result came from divisor == 0.

Function
REQ-013 FSM states SHALL be exactly IDLE, BUSY and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept: the block SHALL accept an operand pair on an edge where the FSM is in IDLE and in_valid=1; it SHALL capture dividend and divisor on that edge (E0).
REQ-016 Accept with divisor != 0: the FSM SHALL go to BUSY, iteration count = 0, partial remainder = 0.
REQ-017 Accept with divisor == 0: the FSM SHALL go directly to DONE with quotient=8'hFF, remainder=dividend[3:0], div_by_zero=1; out_valid SHALL be visible in the cycle after E0.
REQ-018 BUSY algorithm: unsigned restoring division, one quotient bit per edge, MSB first.
REQ-019 Per BUSY iteration: the block SHALL form the 5-bit trial value {rem[3:0], next dividend bit}.
REQ-020 If trial >= divisor, the block SHALL store rem = trial - divisor and set the quotient bit to 1.
REQ-021 Otherwise the block SHALL store rem = trial[3:0] and set the quotient bit to 0.
REQ-022 BUSY SHALL last exactly 8 edges (E1..E8); at E8 the FSM SHALL enter DONE.
REQ-023 For a nonzero divisor, out_valid SHALL first be visible in the cycle after E8 (latency 8 cycles from accept).
REQ-024 Results SHALL satisfy quotient*divisor + remainder == dividend and remainder < divisor for every nonzero divisor; div_by_zero SHALL be 0 in that case.
REQ-025 In DONE, quotient, remainder and div_by_zero SHALL hold stable while out_ready=0.
REQ-026 An edge with out_valid=1 and out_ready=1 SHALL return the FSM to IDLE; quotient, remainder and div_by_zero SHALL retain their values until the next accept overwrites them.
REQ-027 There SHALL be no overlap: a new operand pair is not accepted in the same cycle a result is consumed; in_ready rises in the cycle after consumption.
REQ-028 In BUSY and DONE, in_valid, dividend and divisor SHALL be ignored; operand changes SHALL NOT affect the in-flight result.
REQ-029 out_ready SHALL be ignored outside DONE.
REQ-030 No combinational path SHALL exist from any input to any output; all outputs SHALL be registered or decoded from the registered state.

Reset
REQ-031 When rst=1 on an edge, the FSM SHALL go to IDLE and quotient, remainder, div_by_zero and the internal count and partial remainder SHALL be cleared to 0.
REQ-032 Outputs after that reset edge SHALL be in_ready=1 and out_valid=0.
REQ-033 rst SHALL take priority over every other input on the same edge.
REQ-034 A reset during BUSY or DONE SHALL discard the in-flight operation with no result issued; the first accept after reset behaves as from power-up.

Verification
REQ-035 Divide 200/7 with out_ready=1 -> out_valid in the cycle after E8, quotient=28, remainder=4, div_by_zero=0, then in_ready=1 one cycle later.
REQ-036 Divide 255/1 -> quotient=255, remainder=0; divide 13/15 -> quotient=0, remainder=13.
REQ-037 Divide 100/0 -> out_valid in the cycle after E0, quotient=8'hFF, remainder=4, div_by_zero=1.
REQ-038 Divide 200/7 with out_ready held 0 for 5 cycles in DONE -> outputs stay at 28/4, in_ready stays 0, and in_valid pulses with other operands are ignored; with out_ready=1 -> IDLE.
REQ-039 Assert rst at the 4th BUSY edge -> in the next cycle in_ready=1, out_valid=0, outputs 0; a following 50/3 -> quotient=16, remainder=2.
REQ-040 Random sweep of all 4096 operand pairs with random out_ready stalls -> every result matches the reference model and REQ-024.

Source files
------------

// File: rtl/seq_div_8x4.sv
// seq_div_8x4: sequential 8-bit by 4-bit unsigned restoring divider with valid/ready handshakes
module seq_div_8x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [2:0] cnt;
  logic [3:0] rem, dvs, diff;
  logic [7:0] q;
  logic [4:0] trial;
  logic dz, fit;
  // q starts as the dividend and shifts quotient bits in from the right as dividend bits leave the top
  assign trial = {rem, q[7]};
  assign fit = trial >= {1'b0, dvs};
  assign diff = trial[3:0] - dvs;
  always_comb begin
    state_nxt = IDLE;
    state_nxt = state == IDLE ? (in_valid ? (divisor == 4'd0 ? DONE : BUSY) : IDLE) :
                state == BUSY ? (cnt == 3'd7 ? DONE : BUSY) :
                state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 3'd0;
      rem <= 4'd0;
      dvs <= 4'd0;
      q   <= 8'd0;
      dz  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      cnt <= 3'd0;
      dvs <= divisor;
      dz  <= divisor == 4'd0;
      rem <= divisor == 4'd0 ? dividend[3:0] : 4'd0;
      q   <= divisor == 4'd0 ? 8'hFF : dividend;
    end else if (state == BUSY) begin
      cnt <= cnt + 3'd1;
      rem <= fit ? diff : trial[3:0];
      q   <= {q[6:0], fit};
    end
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign quotient = q;
  assign remainder = rem;
  assign div_by_zero = dz;
endmodule

// File: tb/tb_seq_div_8x4.sv
// tb_seq_div_8x4: directed and randomized checks of seq_div_8x4 against an arithmetic reference
module tb_seq_div_8x4;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [3:0] divisor = 4'd0;
  logic in_ready, out_valid, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;
  int passed = 0, total = 0;

  seq_div_8x4 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] model(input int a, input int b);
    if (b == 0) return {8'hFF, 4'(a % 16), 1'b1};
    return {8'(a / b), 4'(a % b), 1'b0};
  endfunction

  task automatic start(input logic [7:0] a, input logic [3:0] b);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    dividend = a;
    divisor = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit noise, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = 8'($urandom);
        divisor = 4'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    if (out_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if ({quotient, remainder, div_by_zero} !== 13'd0)
      $display("FAIL reset_outputs got q=%0d r=%0d dz=%b want 0/0/0", quotient, remainder, div_by_zero); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] a [3] = '{8'd200, 8'd255, 8'd13};
    logic [3:0] b [3] = '{4'd7, 4'd1, 4'd15};
    logic [7:0] eq [3] = '{8'd28, 8'd255, 8'd0};
    logic [3:0] er [3] = '{4'd4, 4'd0, 4'd13};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start(a[i], b[i]);
      wait_done(0, lat);
      total++; if (lat != 8) $display("FAIL basic_latency %0d/%0d got %0d want 8", a[i], b[i], lat); else passed++;
      total++; if ({quotient, remainder, div_by_zero} !== {eq[i], er[i], 1'b0})
        $display("FAIL basic_result %0d/%0d got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=0",
                 a[i], b[i], quotient, remainder, div_by_zero, eq[i], er[i]); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL basic_no_overlap got in_ready=%b want 0", in_ready); else passed++;
      @(negedge clk);
      total++; if ({in_ready, out_valid} !== 2'b10)
        $display("FAIL basic_consume got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else passed++;
      total++; if ({quotient, remainder} !== {eq[i], er[i]})
        $display("FAIL basic_retain got q=%0d r=%0d want q=%0d r=%0d", quotient, remainder, eq[i], er[i]); else passed++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_div_zero;
    int lat;
    start(8'd100, 4'd0);
    wait_done(0, lat);
    total++; if (lat != 0) $display("FAIL dz_latency got %0d want 0", lat); else passed++;
    total++; if ({quotient, remainder, div_by_zero} !== {8'hFF, 4'd4, 1'b1})
      $display("FAIL dz_result got q=%0d r=%0d dz=%b want q=255 r=4 dz=1", quotient, remainder, div_by_zero); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {2'b10, 8'hFF, 4'd4, 1'b1})
      $display("FAIL dz_consume got rdy=%b vld=%b q=%0d r=%0d dz=%b want 1/0/255/4/1",
               in_ready, out_valid, quotient, remainder, div_by_zero); else passed++;
  endtask

  task automatic test_stall;
    int lat;
    start(8'd200, 4'd7);
    wait_done(1, lat);
    total++; if (lat != 8) $display("FAIL stall_latency got %0d want 8", lat); else passed++;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = 8'($urandom);
      divisor = 4'($urandom);
      @(negedge clk);
      total++; if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {2'b01, 8'd28, 4'd4, 1'b0})
        $display("FAIL stall_hold cycle %0d got rdy=%b vld=%b q=%0d r=%0d dz=%b want 0/1/28/4/0",
                 i, in_ready, out_valid, quotient, remainder, div_by_zero); else passed++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL stall_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else passed++;
  endtask

  task automatic test_reset_busy;
    int lat;
    start(8'd200, 4'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {2'b10, 13'd0})
      $display("FAIL busy_reset got rdy=%b vld=%b q=%0d r=%0d dz=%b want 1/0/0/0/0",
               in_ready, out_valid, quotient, remainder, div_by_zero); else passed++;
    start(8'd50, 4'd3);
    wait_done(0, lat);
    total++; if (lat != 8 || {quotient, remainder, div_by_zero} !== {8'd16, 4'd2, 1'b0})
      $display("FAIL after_reset got lat=%0d q=%0d r=%0d dz=%b want 8/16/2/0", lat, quotient, remainder, div_by_zero); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_sweep;
    int lat, stall;
    logic [12:0] exp_v;
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++) begin
        exp_v = model(a, b);
        start(8'(a), 4'(b));
        wait_done(1, lat);
        stall = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 3)) : 0;
        repeat (stall) @(negedge clk);
        total++; if (lat != (b == 0 ? 0 : 8)) $display("FAIL sweep_latency %0d/%0d got %0d", a, b, lat); else passed++;
        total++; if ({quotient, remainder, div_by_zero} !== exp_v)
          $display("FAIL sweep_result %0d/%0d got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                   a, b, quotient, remainder, div_by_zero, exp_v[12:5], exp_v[4:1], exp_v[0]); else passed++;
        if (b != 0) begin
          total++; if (int'(quotient) * b + int'(remainder) != a || int'(remainder) >= b)
            $display("FAIL sweep_identity %0d/%0d got q=%0d r=%0d", a, b, quotient, remainder); else passed++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
      end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_div_zero;
    test_stall;
    test_reset_busy;
    test_sweep;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
